// File: rtl/powerup_scheduler_if.sv
// Signal bundle between the power-pack scheduler and the game logic / pack renderer.
// The game side (master) drives frame/collision events; the scheduler (slave) drives pack and effect controls.
interface powerup_scheduler_if;
  logic       frame_tick;
  logic       game_active;
  logic       pack_hit;
  logic       last_hitter;
  logic [1:0] pack_mode;
  logic       p1_shield_used;
  logic       p2_shield_used;
  logic       spawn;
  logic       eaten;
  logic       pack_active;
  logic       p1_shrink;
  logic       p2_shrink;
  logic       p1_boost;
  logic       p2_boost;
  logic       p1_shield;
  logic       p2_shield;
  logic       p1_extra;
  logic       p2_extra;

  modport master (
    output frame_tick, game_active, pack_hit, last_hitter, pack_mode,
           p1_shield_used, p2_shield_used,
    input  spawn, eaten, pack_active, p1_shrink, p2_shrink, p1_boost, p2_boost,
           p1_shield, p2_shield, p1_extra, p2_extra
  );

  modport slave (
    input  frame_tick, game_active, pack_hit, last_hitter, pack_mode,
           p1_shield_used, p2_shield_used,
    output spawn, eaten, pack_active, p1_shrink, p2_shrink, p1_boost, p2_boost,
           p1_shield, p2_shield, p1_extra, p2_extra
  );
endinterface

// File: rtl/powerup_scheduler.sv
// Power-pack sequencer: spawns a pack, times its life, resolves claims into
// per-player timed effects (shrink/boost/shield) or a one-shot extra life.
module powerup_scheduler #(
  parameter int SPAWN_FRAMES  = 300,
  parameter int LIFE_FRAMES   = 600,
  parameter int EFFECT_FRAMES = 480,
  parameter int CNT_W         = 10
) (
  input logic                clk,
  input logic                reset,
  powerup_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SPAWN, S_ACTIVE, S_CLAIM, S_EXPIRE
  } state_t;

  localparam logic [1:0] MODE_SHRINK = 2'b00;
  localparam logic [1:0] MODE_BOOST  = 2'b01;
  localparam logic [1:0] MODE_EXTRA  = 2'b10;
  localparam logic [1:0] MODE_SHIELD = 2'b11;

  localparam logic [CNT_W-1:0] SPAWN_LAST  = CNT_W'(SPAWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] LIFE_LAST   = CNT_W'(LIFE_FRAMES - 1);
  localparam logic [CNT_W-1:0] EFFECT_LOAD = CNT_W'(EFFECT_FRAMES);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [1:0]                  mode_q, mode_d;
  logic                        hitter_q, hitter_d;
  logic [1:0][CNT_W-1:0]       shrink_q, shrink_d;
  logic [1:0][CNT_W-1:0]       boost_q, boost_d;
  logic [1:0][CNT_W-1:0]       shield_q, shield_d;
  logic [1:0]                  ld_shrink, ld_boost, ld_shield;
  logic [1:0]                  shield_used;
  logic                        spawn_q, spawn_d;
  logic                        eaten_q, eaten_d;
  logic                        active_q, active_d;
  logic [1:0]                  extra_q, extra_d;

  // Load beats clear beats tick; the decrement saturates at zero.
  function automatic logic [CNT_W-1:0] timer_next(input logic [CNT_W-1:0] cur,
                                                  input logic load,
                                                  input logic clr,
                                                  input logic tick);
    if (load)                  return EFFECT_LOAD;
    if (clr)                   return '0;
    if (tick && (cur != '0))   return cur - CNT_W'(1);
    return cur;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.game_active) state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.game_active)                            state_d = S_IDLE;
        else if (bus.frame_tick && (cnt_q == SPAWN_LAST)) state_d = S_SPAWN;
      end
      S_SPAWN:  state_d = S_ACTIVE;
      S_ACTIVE: begin
        if (!bus.game_active)                            state_d = S_EXPIRE;
        else if (bus.pack_hit)                           state_d = S_CLAIM;
        else if (bus.frame_tick && (cnt_q == LIFE_LAST))  state_d = S_EXPIRE;
      end
      S_CLAIM, S_EXPIRE: state_d = bus.game_active ? S_WAIT : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    spawn_d   = (state_q == S_SPAWN);
    eaten_d   = (state_q == S_CLAIM) || (state_q == S_EXPIRE);
    active_d  = (state_q == S_ACTIVE);
    extra_d   = '0;
    ld_shrink = '0;
    ld_boost  = '0;
    ld_shield = '0;
    if (state_q == S_CLAIM) begin
      case (mode_q)
        MODE_SHRINK: ld_shrink[~hitter_q] = 1'b1;
        MODE_BOOST:  ld_boost[hitter_q]   = 1'b1;
        MODE_SHIELD: ld_shield[hitter_q]  = 1'b1;
        MODE_EXTRA:  extra_d[hitter_q]    = 1'b1;
        default:     extra_d              = '0;
      endcase
    end
  end

  // Frame counter restarts on every state change; claim attributes latch on the hit.
  always_comb begin
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    hitter_d = hitter_q;
    if ((state_d != state_q) || (state_q == S_IDLE))
      cnt_d = '0;
    else if (bus.frame_tick && ((state_q == S_WAIT) || (state_q == S_ACTIVE)))
      cnt_d = cnt_q + CNT_W'(1);
    if ((state_q == S_ACTIVE) && (state_d == S_CLAIM)) begin
      mode_d   = bus.pack_mode;
      hitter_d = bus.last_hitter;
    end
  end

  assign shield_used = {bus.p2_shield_used, bus.p1_shield_used};

  always_comb begin
    shrink_d = '0;
    boost_d  = '0;
    shield_d = '0;
    if (state_q != S_IDLE) begin
      for (int p = 0; p < 2; p++) begin
        shrink_d[p] = timer_next(shrink_q[p], ld_shrink[p], 1'b0, bus.frame_tick);
        boost_d[p]  = timer_next(boost_q[p], ld_boost[p], 1'b0, bus.frame_tick);
        shield_d[p] = timer_next(shield_q[p], ld_shield[p], shield_used[p], bus.frame_tick);
      end
    end
  end

  // ---- register stage: counters, timers and registered outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      mode_q   <= '0;
      hitter_q <= 1'b0;
      shrink_q <= '0;
      boost_q  <= '0;
      shield_q <= '0;
      spawn_q  <= 1'b0;
      eaten_q  <= 1'b0;
      active_q <= 1'b0;
      extra_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      hitter_q <= hitter_d;
      shrink_q <= shrink_d;
      boost_q  <= boost_d;
      shield_q <= shield_d;
      spawn_q  <= spawn_d;
      eaten_q  <= eaten_d;
      active_q <= active_d;
      extra_q  <= extra_d;
    end
  end

  assign bus.spawn       = spawn_q;
  assign bus.eaten       = eaten_q;
  assign bus.pack_active = active_q;
  assign bus.p1_shrink   = (shrink_q[0] != '0);
  assign bus.p2_shrink   = (shrink_q[1] != '0);
  assign bus.p1_boost    = (boost_q[0] != '0);
  assign bus.p2_boost    = (boost_q[1] != '0);
  assign bus.p1_shield   = (shield_q[0] != '0);
  assign bus.p2_shield   = (shield_q[1] != '0);
  assign bus.p1_extra    = extra_q[0];
  assign bus.p2_extra    = extra_q[1];

endmodule
